// File: rtl/ex_md_stage.sv
// Execute stage with operand forwarding, ALU, and a multi-cycle multiply/divide
// unit that owns the HI/LO registers; drives the EX/MEM pipeline register.
module ex_md_stage #(
    parameter int XLEN    = 32,
    parameter int REGW    = 5,
    parameter int MUL_LAT = 4,
    parameter int MEMC_W  = 1,
    parameter int WBC_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_flush,
    input  logic              ex_valid,
    input  logic [3:0]        alu_op,
    input  logic              src_b_imm,
    input  logic [2:0]        md_op,
    input  logic [1:0]        wb_sel,
    input  logic [REGW-1:0]   rs_idx,
    input  logic [REGW-1:0]   rt_idx,
    input  logic [REGW-1:0]   rw_idx,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc_next,
    input  logic [4:0]        sa,
    input  logic [MEMC_W-1:0] mem_ctrl,
    input  logic [WBC_W-1:0]  wb_ctrl,
    input  logic              fm_we,
    input  logic [REGW-1:0]   fm_idx,
    input  logic [XLEN-1:0]   fm_val,
    input  logic              fw_we,
    input  logic [REGW-1:0]   fw_idx,
    input  logic [XLEN-1:0]   fw_val,
    output logic              ex_stall,
    output logic              md_busy,
    output logic              o_valid,
    output logic [MEMC_W-1:0] o_mem_ctrl,
    output logic [WBC_W-1:0]  o_wb_ctrl,
    output logic [REGW-1:0]   o_rw,
    output logic [XLEN-1:0]   o_result,
    output logic [XLEN-1:0]   o_store
);

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } md_state_t;

    md_state_t state, state_nx;

    logic [XLEN-1:0]   a_val, rt_val, b_val, alu_res, wb_res;
    logic              issue, is_mul, is_div;
    logic              mul_done, div_done;

    logic [XLEN-1:0]   hi, lo;
    logic [XLEN-1:0]   op_a, op_b, rem;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q, neg_r, div_zero, mul_sgn;

    logic [XLEN:0]     rem_sh, diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nx, quo_nx, q_fix, r_fix;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;

    // MEM-stage source has priority over WB; r0 is hardwired and never forwarded
    always_comb begin
        a_val = rd1;
        if (rs_idx != '0) begin
            if (fm_we && fm_idx == rs_idx)
                a_val = fm_val;
            else if (fw_we && fw_idx == rs_idx)
                a_val = fw_val;
        end
        rt_val = rd2;
        if (rt_idx != '0) begin
            if (fm_we && fm_idx == rt_idx)
                rt_val = fm_val;
            else if (fw_we && fw_idx == rt_idx)
                rt_val = fw_val;
        end
        b_val = src_b_imm ? imm : rt_val;
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = a_val + b_val;
            4'd1:    alu_res = a_val - b_val;
            4'd2:    alu_res = a_val & b_val;
            4'd3:    alu_res = a_val | b_val;
            4'd4:    alu_res = a_val ^ b_val;
            4'd5:    alu_res = ~(a_val | b_val);
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, $signed(a_val) < $signed(b_val)};
            4'd7:    alu_res = {{(XLEN-1){1'b0}}, a_val < b_val};
            4'd8:    alu_res = b_val << sa;
            4'd9:    alu_res = b_val >> sa;
            4'd10:   alu_res = $signed(b_val) >>> sa;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        wb_res = alu_res;
        case (wb_sel)
            2'd0: wb_res = alu_res;
            2'd1: wb_res = pc_next;
            2'd2: wb_res = hi;
            2'd3: wb_res = lo;
            default: wb_res = alu_res;
        endcase
    end

    assign md_busy  = (state != S_IDLE);
    assign ex_stall = ex_valid && md_busy && ((md_op != '0) || wb_sel[1]);
    assign issue    = ex_valid && !ex_flush && !ex_stall && (md_op != '0);
    assign is_mul   = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_div   = (md_op == MD_DIV)  || (md_op == MD_DIVU);

    // Restoring step on magnitudes; op_a shifts dividend bits out and quotient bits in
    always_comb begin
        rem_sh = {rem, op_a[XLEN-1]};
        diff   = rem_sh - {1'b0, op_b};
        q_bit  = ~diff[XLEN];
        rem_nx = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx = {op_a[XLEN-2:0], q_bit};
        q_fix  = neg_q ? -quo_nx : quo_nx;
        r_fix  = neg_r ? -rem_nx : rem_nx;
    end

    always_comb begin
        ext_a = {{XLEN{mul_sgn & op_a[XLEN-1]}}, op_a};
        ext_b = {{XLEN{mul_sgn & op_b[XLEN-1]}}, op_b};
        prod  = ext_a * ext_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mul_done = 1'b0;
        div_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue && is_mul)
                    state_nx = S_MUL;
                else if (issue && is_div)
                    state_nx = S_DIV;
            end
            S_MUL: begin
                if (cnt == MUL_LAST) begin
                    mul_done = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DIV: begin
                if (cnt == DIV_LAST) begin
                    div_done = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Issue can only happen in IDLE because busy stalls any md_op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi       <= '0;
            lo       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            mul_sgn  <= 1'b0;
        end else if (issue) begin
            cnt <= '0;
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    op_a    <= a_val;
                    op_b    <= rt_val;
                    mul_sgn <= (md_op == MD_MULT);
                end
                MD_DIV, MD_DIVU: begin
                    op_a     <= ((md_op == MD_DIV) && a_val[XLEN-1]) ? -a_val : a_val;
                    op_b     <= ((md_op == MD_DIV) && rt_val[XLEN-1]) ? -rt_val : rt_val;
                    rem      <= '0;
                    neg_q    <= (md_op == MD_DIV) && (a_val[XLEN-1] ^ rt_val[XLEN-1]);
                    neg_r    <= (md_op == MD_DIV) && a_val[XLEN-1];
                    div_zero <= (rt_val == '0);
                end
                MD_MTHI: hi <= a_val;
                MD_MTLO: lo <= a_val;
                default: ;
            endcase
        end else if (state == S_MUL) begin
            if (mul_done) begin
                hi <= prod[2*XLEN-1:XLEN];
                lo <= prod[XLEN-1:0];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (state == S_DIV) begin
            op_a <= quo_nx;
            rem  <= rem_nx;
            if (div_done) begin
                hi <= r_fix;
                lo <= div_zero ? '1 : q_fix;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Flush or stall inserts a bubble; data fields keep their last value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid    <= 1'b0;
            o_mem_ctrl <= '0;
            o_wb_ctrl  <= '0;
            o_rw       <= '0;
            o_result   <= '0;
            o_store    <= '0;
        end else if (ex_flush || ex_stall) begin
            o_valid    <= 1'b0;
            o_mem_ctrl <= '0;
            o_wb_ctrl  <= '0;
        end else begin
            o_valid    <= ex_valid;
            o_mem_ctrl <= mem_ctrl;
            o_wb_ctrl  <= wb_ctrl;
            o_rw       <= rw_idx;
            o_result   <= wb_res;
            o_store    <= rt_val;
        end
    end

endmodule

// File: tb/tb_ex_md_stage.sv
// Scoreboard bench for ex_md_stage: expected results are queued at issue and
// compared when the EX/MEM register presents a valid instruction.
module tb_ex_md_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_flush, ex_valid, src_b_imm;
    logic [3:0]  alu_op;
    logic [2:0]  md_op;
    logic [1:0]  wb_sel;
    logic [4:0]  rs_idx, rt_idx, rw_idx, sa;
    logic [31:0] rd1, rd2, imm, pc_next;
    logic [0:0]  mem_ctrl;
    logic [4:0]  wb_ctrl;
    logic        fm_we, fw_we;
    logic [4:0]  fm_idx, fw_idx;
    logic [31:0] fm_val, fw_val;
    logic        ex_stall, md_busy, o_valid;
    logic [0:0]  o_mem_ctrl;
    logic [4:0]  o_wb_ctrl, o_rw;
    logic [31:0] o_result, o_store;

    always #5 clk = ~clk;

    ex_md_stage #(.XLEN(32), .REGW(5), .MUL_LAT(4), .MEMC_W(1), .WBC_W(5)) dut (
        .clk(clk), .rst(rst), .ex_flush(ex_flush), .ex_valid(ex_valid),
        .alu_op(alu_op), .src_b_imm(src_b_imm), .md_op(md_op), .wb_sel(wb_sel),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rw_idx(rw_idx),
        .rd1(rd1), .rd2(rd2), .imm(imm), .pc_next(pc_next), .sa(sa),
        .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .fm_we(fm_we), .fm_idx(fm_idx), .fm_val(fm_val),
        .fw_we(fw_we), .fw_idx(fw_idx), .fw_val(fw_val),
        .ex_stall(ex_stall), .md_busy(md_busy), .o_valid(o_valid),
        .o_mem_ctrl(o_mem_ctrl), .o_wb_ctrl(o_wb_ctrl), .o_rw(o_rw),
        .o_result(o_result), .o_store(o_store)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] pa [3] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [31:0] pb [3] = '{32'd3, 32'd1,         32'h0000_000F};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] s);
        int sa_i, sb_i;
        sa_i = a;
        sb_i = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa_i < sb_i) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << s;
            4'd9:  return b >> s;
            4'd10: return sb_i >>> s;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst && o_valid) begin
            if (exp_q.size() == 0)
                check_eq("spurious_valid", 32'(o_valid), 32'd0);
            else
                check_eq("result", o_result, exp_q.pop_front());
        end
    end

    // Drive one instruction, hold it through any stall, queue its expected result
    task automatic exec(input logic [3:0] aop, input logic [2:0] mop, input logic [1:0] wsel,
                        input logic [31:0] a, input logic [31:0] b, input logic flush,
                        output int stalls);
        logic [31:0] e;
        longint p;
        longint unsigned pu;
        alu_op = aop; md_op = mop; wb_sel = wsel;
        rs_idx = 5'd1; rt_idx = 5'd2; rw_idx = 5'd7;
        rd1 = a; rd2 = b; sa = a[4:0]; src_b_imm = 1'b0;
        mem_ctrl = 1'b1; wb_ctrl = 5'h11;
        ex_valid = 1'b1; ex_flush = flush;
        stalls = 0;
        @(negedge clk);
        while (ex_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (ex_stall) check_eq("stall_timeout", 32'(ex_stall), 32'd0);
        case (wsel)
            2'd0: e = ref_alu(aop, a, b, a[4:0]);
            2'd1: e = pc_next;
            2'd2: e = m_hi;
            default: e = m_lo;
        endcase
        if (!flush) begin
            exp_q.push_back(e);
            case (mop)
                3'd1: begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    m_hi = p[63:32]; m_lo = p[31:0];
                end
                3'd2: begin
                    pu = 64'(a) * 64'(b);
                    m_hi = pu[63:32]; m_lo = pu[31:0];
                end
                3'd3: begin
                    if (b == 0) begin m_lo = '1; m_hi = a; end
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = '0; end
                    else begin m_lo = $signed(a) / $signed(b); m_hi = $signed(a) % $signed(b); end
                end
                3'd4: begin
                    if (b == 0) begin m_lo = '1; m_hi = a; end
                    else begin m_lo = a / b; m_hi = a % b; end
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_flush = 1'b0; md_op = '0;
    endtask

    task automatic fwd_case(input string tag, input logic [4:0] rs, input logic mwe,
                            input logic [4:0] midx, input logic wwe, input logic [4:0] widx,
                            input logic [31:0] expv);
        alu_op = 4'd0; md_op = '0; wb_sel = 2'd0; src_b_imm = 1'b1; imm = 32'd1;
        rs_idx = rs; rt_idx = rs; rw_idx = 5'd9; rd1 = 32'd99; rd2 = 32'd99;
        fm_we = mwe; fm_idx = midx; fm_val = 32'd10;
        fw_we = wwe; fw_idx = widx; fw_val = 32'd20;
        mem_ctrl = 1'b1; wb_ctrl = 5'h15; ex_valid = 1'b1;
        @(negedge clk);
        exp_q.push_back(expv + 32'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_store"}, o_store, expv);
        check_eq({tag, "_rw"}, 32'(o_rw), 32'd9);
        check_eq({tag, "_wbc"}, 32'(o_wb_ctrl), 32'h15);
        ex_valid = 1'b0; fm_we = 1'b0; fw_we = 1'b0; src_b_imm = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int busy_cnt;
        rst = 1'b0; ex_flush = 0; ex_valid = 1; src_b_imm = 0; alu_op = 0;
        md_op = 3'd3; wb_sel = 2'd2; rs_idx = 0; rt_idx = 0; rw_idx = 0;
        rd1 = 0; rd2 = 0; imm = 0; pc_next = 32'h0040_0010; sa = 0;
        mem_ctrl = 0; wb_ctrl = 0; fm_we = 0; fm_idx = 0; fm_val = 0;
        fw_we = 0; fw_idx = 0; fw_val = 0;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_result", o_result, 32'd0);
        check_eq("rst_store", o_store, 32'd0);
        check_eq("rst_wbc", 32'(o_wb_ctrl), 32'd0);
        check_eq("rst_busy", 32'(md_busy), 32'd0);
        check_eq("rst_stall", 32'(ex_stall), 32'd0);
        ex_valid = 0; md_op = 0; wb_sel = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        exec(4'd0, 3'd0, 2'd2, 32'd1, 32'd2, 1'b0, st);
        for (int p = 0; p < 3; p++)
            for (int op = 0; op < 12; op++)
                exec(4'(op), 3'd0, 2'd0, pa[p], pb[p], 1'b0, st);
        exec(4'd0, 3'd0, 2'd1, 32'd4, 32'd4, 1'b0, st);

        exec(4'd0, 3'd2, 2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, st);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);
        check_eq("mul_stall", 32'(st), 32'd4);
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        check_eq("mflo_nostall", 32'(st), 32'd0);

        exec(4'd0, 3'd3, 2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0, st);
        busy_cnt = 0;
        @(negedge clk);
        while (md_busy && busy_cnt < 100) begin
            busy_cnt++;
            @(negedge clk);
        end
        check_eq("div_busy_cycles", 32'(busy_cnt), 32'd32);
        @(posedge clk);
        #1;
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);

        exec(4'd0, 3'd4, 2'd0, 32'd5, 32'd0, 1'b0, st);
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        check_eq("divu0_stall", 32'(st), 32'd32);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd3, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st);
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd3, 2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, st);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd1, 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, st);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd5, 2'd0, 32'hCAFE_0001, 32'd0, 1'b0, st);
        exec(4'd0, 3'd6, 2'd0, 32'h1234_5678, 32'd0, 1'b0, st);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);

        fwd_case("fwd_mem", 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'd10);
        fwd_case("fwd_wb",  5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 32'd20);
        fwd_case("fwd_r0",  5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'd99);
        fwd_case("fwd_miss", 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 32'd20);

        exec(4'd0, 3'd3, 2'd0, 32'd100, 32'd7, 1'b1, st);
        @(negedge clk);
        check_eq("flush_issue_busy", 32'(md_busy), 32'd0);
        check_eq("flush_issue_valid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd3, 2'd0, 32'd100, 32'd7, 1'b0, st);
        exec(4'd1, 3'd0, 2'd0, 32'd9, 32'd1, 1'b1, st);
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);

        exec(4'd0, 3'd3, 2'd0, 32'd1000, 32'd3, 1'b0, st);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(md_busy), 32'd0);
        check_eq("midrst_valid", 32'(o_valid), 32'd0);
        check_eq("midrst_result", o_result, 32'd0);
        check_eq("midrst_rw", 32'(o_rw), 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exec(4'd0, 3'd0, 2'd3, 32'd0, 32'd0, 1'b0, st);
        check_eq("postrst_stall", 32'(st), 32'd0);
        exec(4'd0, 3'd0, 2'd2, 32'd0, 32'd0, 1'b0, st);

        @(negedge clk);
        @(posedge clk);
        #1;
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
